udp_line_sched: RTL and testbench

- Parametrised N-camera line scheduler. It sits between the per-camera line buffers and the single UDP transmitter.
- Each line buffer raises a one-cycle "line ready" request carrying a row number. The scheduler queues one pending line per camera and arbitrates among cameras (round-robin or fixed priority).
- For the granted line it drives the UDP trigger and the packet index {camera id, row}, then waits for transmit completion, with a watchdog timeout.
- It supersedes the hard-wired single-camera trigger/index path, adding drop accounting and a channel enable mask.

---
 rtl/udp_sched_pkg.sv | 20 ++
 rtl/udp_line_sched_arbiter.sv | 40 ++++
 rtl/udp_line_sched.sv | 135 +++++++++++++
 tb/tb_udp_line_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_sched_pkg.sv
// Shared types and helpers for the camera line scheduler.
package udp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRIG,
    WAIT
  } sched_state_e;

  // Width of a channel-number field; never narrower than one bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot camera id counted from the MSB of an id_w-bit field.
  function automatic logic [31:0] cam_id(input int ch, input int id_w);
    return 32'd1 << (id_w - 1 - ch);
  endfunction

endpackage

// File: rtl/udp_line_sched_arbiter.sv
// Combinational arbiter: round-robin from a pointer, or fixed lowest-index priority.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] gnt,
  output logic             vld
);

  logic [2*N-1:0] rot;
  int             sum;

  // Pick the first requester, either rotated from ptr or from index 0.
  always_comb begin
    gnt = '0;
    vld = 1'b0;
    sum = 0;
    rot = {req, req} >> ptr;
    if (mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          gnt = SEL_W'(i);
          vld = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!vld && rot[k]) begin
          vld = 1'b1;
          sum = int'(ptr) + k;
          gnt = SEL_W'((sum >= N) ? sum - N : sum);
        end
      end
    end
  end

endmodule

// File: rtl/udp_line_sched.sv
// N-camera line scheduler: queues one line per camera, arbitrates, and
// hands {id,row} to the UDP transmitter with a completion watchdog.
module udp_line_sched
  import udp_sched_pkg::*;
#(
  parameter int N_CAM   = 2,
  parameter int ROW_W   = 10,
  parameter int ID_W    = 5,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 125000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CAM-1:0]          req,
  input  logic [N_CAM*ROW_W-1:0]    row,
  input  logic [N_CAM-1:0]          en_mask,
  input  logic                      prio_mode,
  input  logic                      clr_stats,
  input  logic                      tx_done,
  output logic                      tx_trig,
  output logic [ID_W+ROW_W-1:0]     tx_index,
  output logic [sel_w(N_CAM)-1:0]   tx_sel,
  output logic                      busy,
  output logic [N_CAM*CNT_W-1:0]    drop_cnt,
  output logic                      timeout_err
);

  localparam int SEL_W = sel_w(N_CAM);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sched_state_e     state;
  logic [N_CAM-1:0] pending;
  logic [N_CAM-1:0] elig;
  logic [ROW_W-1:0] row_lat [N_CAM];
  logic [CNT_W-1:0] drop    [N_CAM];
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic             grant_fire;
  logic [WD_W-1:0]  wd;

  assign elig       = pending & en_mask;
  assign grant_fire = (state == IDLE) && gnt_vld;

  rr_arbiter #(
    .N     (N_CAM),
    .SEL_W (SEL_W)
  ) u_arb (
    .req  (elig),
    .ptr  (ptr),
    .mode (prio_mode),
    .gnt  (gnt),
    .vld  (gnt_vld)
  );

  for (genvar i = 0; i < N_CAM; i++) begin : g_cnt
    assign drop_cnt[i*CNT_W +: CNT_W] = drop[i];
  end

  // Per-channel pending latch, newest-row-wins capture and saturating drop count.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      for (int i = 0; i < N_CAM; i++) begin
        row_lat[i] <= '0;
        drop[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_CAM; i++) begin
        if (!en_mask[i]) begin
          pending[i] <= 1'b0;
        end else if (req[i]) begin
          pending[i] <= 1'b1;
          row_lat[i] <= row[i*ROW_W +: ROW_W];
          // A grant in the same cycle consumes the old row, so nothing is lost.
          if (pending[i] && !(grant_fire && gnt == SEL_W'(i)) && drop[i] != CNT_MAX)
            drop[i] <= drop[i] + 1'b1;
        end else if (grant_fire && gnt == SEL_W'(i)) begin
          pending[i] <= 1'b0;
        end
        if (clr_stats) drop[i] <= '0;
      end
    end
  end

  // Grant / trigger / wait-for-done sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      tx_trig     <= 1'b0;
      tx_index    <= '0;
      tx_sel      <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wd          <= '0;
    end else begin
      tx_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            tx_sel   <= gnt;
            tx_index <= {ID_W'(cam_id(int'(gnt), ID_W)), row_lat[gnt]};
            busy     <= 1'b1;
            tx_trig  <= 1'b1;
            state    <= TRIG;
            if (!prio_mode)
              ptr <= (int'(gnt) == N_CAM - 1) ? '0 : gnt + 1'b1;
          end
        end
        TRIG: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (TIMEOUT != 0 && wd == WD_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (clr_stats) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_udp_line_sched.sv
// Bench for udp_line_sched: directed scenarios plus a random soak, every cycle
// compared against a transaction-level reference of the scheduler.
module tb_udp_line_sched;

  localparam int N_CAM   = 2;
  localparam int ROW_W   = 10;
  localparam int ID_W    = 5;
  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_CAM-1:0]       req;
  logic [N_CAM*ROW_W-1:0] row;
  logic [N_CAM-1:0]       en_mask;
  logic                   prio_mode;
  logic                   clr_stats;
  logic                   tx_done;
  logic                   tx_trig;
  logic [ID_W+ROW_W-1:0]  tx_index;
  logic                   tx_sel;
  logic                   busy;
  logic [N_CAM*CNT_W-1:0] drop_cnt;
  logic                   timeout_err;

  always #5 clk = ~clk;

  udp_line_sched #(
    .N_CAM(N_CAM), .ROW_W(ROW_W), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .row(row), .en_mask(en_mask),
    .prio_mode(prio_mode), .clr_stats(clr_stats), .tx_done(tx_done),
    .tx_trig(tx_trig), .tx_index(tx_index), .tx_sel(tx_sel), .busy(busy),
    .drop_cnt(drop_cnt), .timeout_err(timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: a queue slot per camera plus the transmitter transaction in flight.
  bit m_pend [N_CAM];
  int m_row  [N_CAM];
  int m_drop [N_CAM];
  int m_ptr, m_wait, m_idx, m_sel;
  bit m_busy, m_trig, m_terr;

  int cycnt   = 0;
  int done_at = -1;
  bit auto_on = 1'b0;
  int auto_dly = 5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cycnt, obs, exp);
    end
  endtask

  task automatic model_edge();
    int g;
    bit idle, in_trig, in_wait;
    if (rst) begin
      for (int c = 0; c < N_CAM; c++) begin
        m_pend[c] = 0; m_row[c] = 0; m_drop[c] = 0;
      end
      m_ptr = 0; m_wait = 0; m_idx = 0; m_sel = 0;
      m_busy = 0; m_trig = 0; m_terr = 0;
      return;
    end
    idle    = !m_busy;
    in_trig = m_busy && m_trig;
    in_wait = m_busy && !m_trig;
    g = -1;
    if (idle) begin
      if (prio_mode) begin
        for (int c = N_CAM - 1; c >= 0; c--)
          if (m_pend[c] && en_mask[c]) g = c;
      end else begin
        for (int k = 0; k < N_CAM; k++) begin
          int c;
          c = (m_ptr + k) % N_CAM;
          if (g < 0 && m_pend[c] && en_mask[c]) g = c;
        end
      end
    end
    if (g >= 0) begin
      m_busy = 1; m_trig = 1; m_sel = g;
      m_idx  = ((16 >> g) << ROW_W) | m_row[g];
      if (!prio_mode) m_ptr = (g + 1) % N_CAM;
    end
    if (in_trig) begin
      m_trig = 0; m_wait = 0;
    end
    if (in_wait) begin
      if (tx_done) m_busy = 0;
      else if (m_wait == TIMEOUT - 1) begin m_terr = 1; m_busy = 0; end
      else m_wait++;
    end
    for (int c = 0; c < N_CAM; c++) begin
      if (!en_mask[c]) m_pend[c] = 0;
      else if (req[c]) begin
        if (m_pend[c] && g != c && m_drop[c] < CMAX) m_drop[c]++;
        m_pend[c] = 1;
        m_row[c]  = int'(row[c*ROW_W +: ROW_W]);
      end else if (g == c) m_pend[c] = 0;
    end
    if (clr_stats) begin
      for (int c = 0; c < N_CAM; c++) m_drop[c] = 0;
      m_terr = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    cycnt++;
    #1;
    chk("tx_trig", 32'(tx_trig), 32'(m_trig));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("tx_sel", 32'(tx_sel), 32'(m_sel));
    chk("tx_index", 32'(tx_index), 32'(m_idx));
    chk("drop0", 32'(drop_cnt[1:0]), 32'(m_drop[0]));
    chk("drop1", 32'(drop_cnt[3:2]), 32'(m_drop[1]));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    if (auto_on) begin
      if (m_trig) done_at = cycnt + auto_dly;
      tx_done = (cycnt == done_at);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_rows(input int r0, input int r1);
    row = {ROW_W'(r1), ROW_W'(r0)};
  endtask

  initial begin
    rst = 1; req = '0; row = '0; en_mask = 2'b11; prio_mode = 0;
    clr_stats = 0; tx_done = 0;
    run(3);
    chk("rst_trig", 32'(tx_trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_index", 32'(tx_index), 32'd0);
    rst = 0;
    run(5);

    // Single request, row 37 on camera 0.
    set_rows(37, 0); req = 2'b01;
    cyc();
    req = 2'b00;
    cyc();
    chk("t1_trig", 32'(tx_trig), 32'd1);
    chk("t1_index", 32'(tx_index), 32'h4025);
    chk("t1_sel", 32'(tx_sel), 32'd0);
    run(3);
    chk("t1_busy", 32'(busy), 32'd1);
    tx_done = 1;
    cyc();
    tx_done = 0;
    chk("t1_idle", 32'(busy), 32'd0);
    run(3);

    // Round-robin with both cameras requesting every cycle.
    auto_on = 1;
    for (int i = 0; i < 20; i++) begin
      req = 2'b11;
      set_rows($urandom_range(0, 1023), $urandom_range(0, 1023));
      cyc();
    end
    req = 2'b00;
    run(40);

    // Fixed priority, then back to round-robin.
    prio_mode = 1;
    for (int i = 0; i < 30; i++) begin
      req = 2'b11;
      set_rows($urandom_range(0, 1023), $urandom_range(0, 1023));
      cyc();
    end
    prio_mode = 0;
    for (int i = 0; i < 30; i++) begin
      req = 2'b11;
      set_rows($urandom_range(0, 1023), $urandom_range(0, 1023));
      cyc();
    end
    req = 2'b00;
    run(40);
    auto_on = 0; tx_done = 0;
    run(2);

    // Watchdog expiry and clear.
    set_rows(100, 0); req = 2'b01;
    cyc();
    req = 2'b00;
    run(12);
    chk("t4_terr", 32'(timeout_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    clr_stats = 1;
    cyc();
    clr_stats = 0;
    chk("t4_clr", 32'(timeout_err), 32'd0);
    chk("t4_drop_clr", 32'(drop_cnt), 32'd0);

    // Disabled channel is ignored.
    en_mask = 2'b01; set_rows(0, 55); req = 2'b10;
    cyc();
    req = 2'b00;
    run(4);
    chk("t5_masked", 32'(busy), 32'd0);
    en_mask = 2'b11;
    // Overwrites while busy saturate; then mask drop discards the pending line.
    set_rows(9, 0); req = 2'b01;
    cyc();
    req = 2'b00;
    cyc();
    for (int i = 0; i < 5; i++) begin
      req = 2'b10; set_rows(0, $urandom_range(0, 1023));
      cyc();
    end
    req = 2'b00;
    chk("t5_sat", 32'(drop_cnt[3:2]), 32'd3);
    en_mask = 2'b01;
    cyc();
    en_mask = 2'b11;
    run(12);
    chk("t5_nogrant", 32'(busy), 32'd0);

    // Reset in the middle of a transfer.
    set_rows(200, 0); req = 2'b01;
    cyc();
    req = 2'b00;
    run(4);
    rst = 1;
    cyc();
    rst = 0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_index", 32'(tx_index), 32'd0);
    chk("t6_terr", 32'(timeout_err), 32'd0);
    tx_done = 1;
    cyc();
    tx_done = 0;
    run(3);
    chk("t6_quiet", 32'(busy), 32'd0);
    set_rows(0, 77); req = 2'b10;
    cyc();
    req = 2'b00;
    cyc();
    chk("t6_trig", 32'(tx_trig), 32'd1);
    chk("t6_index2", 32'(tx_index), 32'(32'h2000 | 77));
    tx_done = 1;
    cyc();
    tx_done = 0;

    // Random soak.
    for (int i = 0; i < 500; i++) begin
      req       = 2'($urandom_range(0, 3));
      set_rows($urandom_range(0, 1023), $urandom_range(0, 1023));
      en_mask   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      if ($urandom_range(0, 40) == 0) prio_mode = ~prio_mode;
      clr_stats = ($urandom_range(0, 30) == 0);
      tx_done   = ($urandom_range(0, 5) == 0);
      rst       = ($urandom_range(0, 200) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
